// File: rtl/cram_pkg.sv
// Shared constants and the next-address source encoding for the CRAM sequencer.
package cram_pkg;

   localparam int          ADR_W           = 11;
   localparam logic [10:0] FORCE_ADR       = 11'o1777;
   localparam int          STACK_DEPTH_DEF = 16;

   typedef enum logic [2:0] {
      FORCE,
      HOLD,
      RET,
      DRAM,
      DISP,
      SKIP,
      JUMP
   } nxt_src_e;

endpackage

// File: rtl/cram_stack.sv
// Return-address call stack: push, pop and replace-top, with sticky overflow and
// underflow flags. An empty stack reads its top as zero.
module cram_stack
   import cram_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH_DEF,
   parameter int W     = ADR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         replace,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic [4:0]   depth,
   output logic         ovf,
   output logic         unf
);

   localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] FULL  = 5'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [4:0]       depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] top_idx;

   always_comb begin
      top_idx = PTR_W'(depth_q - 5'd1);
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      wr_en   = 1'b0;
      wr_idx  = top_idx;
      // Replace on an empty stack is an underflow that still lands in entry 0.
      if (replace) begin
         wr_en = 1'b1;
         if (depth_q == 5'd0) begin
            unf_d   = 1'b1;
            wr_idx  = '0;
            depth_d = 5'd1;
         end
      end else if (push) begin
         if (depth_q == FULL) begin
            ovf_d = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_idx  = PTR_W'(depth_q);
            depth_d = depth_q + 5'd1;
         end
      end else if (pop) begin
         if (depth_q == 5'd0) begin
            unf_d = 1'b1;
         end else begin
            depth_d = depth_q - 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= 5'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // NOTE: stack storage has no reset; entries above depth_q are never read.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem_q[wr_idx] <= din;
      end
   end

   assign top   = (depth_q == 5'd0) ? '0 : mem_q[top_idx];
   assign depth = depth_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: rtl/cram_sequencer.sv
// CRAM next-address sequencer: prioritised source select feeding the cradr
// register, with a call stack for subroutine return dispatch.
module cram_sequencer #(
   parameter int STACK_DEPTH = cram_pkg::STACK_DEPTH_DEF,
   parameter int ADR_W       = cram_pkg::ADR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clkForce1777,
   input  logic             stall,
   input  logic [ADR_W-1:0] j,
   input  logic             call,
   input  logic             ret,
   input  logic             dispEn,
   input  logic [3:0]       dispIn,
   input  logic             dramEn,
   input  logic [9:0]       DRAMj,
   input  logic             skipEn,
   input  logic             skipTrue,
   output logic [ADR_W-1:0] cradr,
   output logic [4:0]       stackDepth,
   output logic             stackErr
);

   cram_pkg::nxt_src_e src;
   logic [ADR_W-1:0]   cradr_q, cradr_d;
   logic [ADR_W-1:0]   stk_top;
   logic               stk_push, stk_pop, stk_replace;
   logic               stk_ovf, stk_unf;

   always_comb begin
      if (clkForce1777)  src = cram_pkg::FORCE;
      else if (stall)    src = cram_pkg::HOLD;
      else if (ret)      src = cram_pkg::RET;
      else if (dramEn)   src = cram_pkg::DRAM;
      else if (dispEn)   src = cram_pkg::DISP;
      else if (skipEn)   src = cram_pkg::SKIP;
      else               src = cram_pkg::JUMP;
   end

   // Addresses are formed by OR only, so the microcode never sees a carry.
   always_comb begin
      cradr_d = j;
      unique case (src)
         cram_pkg::FORCE: cradr_d = ADR_W'(cram_pkg::FORCE_ADR);
         cram_pkg::HOLD:  cradr_d = cradr_q;
         cram_pkg::RET:   cradr_d = stk_top | j;
         cram_pkg::DRAM:  cradr_d = {j[ADR_W-1:10], DRAMj};
         cram_pkg::DISP:  cradr_d = j | ADR_W'(dispIn);
         cram_pkg::SKIP:  cradr_d = j | ADR_W'(skipTrue);
         default:         cradr_d = j;
      endcase
   end

   // A trap saves the interrupted address; a stall freezes the stack entirely.
   always_comb begin
      stk_push    = clkForce1777 || (!stall && call && !ret);
      stk_pop     = !clkForce1777 && !stall && ret && !call;
      stk_replace = !clkForce1777 && !stall && ret && call;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         cradr_q <= '0;
      end else begin
         cradr_q <= cradr_d;
      end
   end

   cram_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADR_W)
   ) u_stack (
      .clk     (clk),
      .reset   (reset),
      .push    (stk_push),
      .pop     (stk_pop),
      .replace (stk_replace),
      .din     (cradr_q),
      .top     (stk_top),
      .depth   (stackDepth),
      .ovf     (stk_ovf),
      .unf     (stk_unf)
   );

   assign cradr    = cradr_q;
   assign stackErr = stk_ovf | stk_unf;

endmodule

// File: tb/tb_cram_sequencer.sv
// Directed bench for cram_sequencer: each step queues its expected cradr, depth
// and error flag, then compares them one time unit after the clock edge.
module tb_cram_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clkForce1777;
   logic        stall;
   logic [10:0] j;
   logic        call;
   logic        ret;
   logic        dispEn;
   logic [3:0]  dispIn;
   logic        dramEn;
   logic [9:0]  DRAMj;
   logic        skipEn;
   logic        skipTrue;
   logic [10:0] cradr;
   logic [4:0]  stackDepth;
   logic        stackErr;

   typedef struct {
      string       tag;
      logic [10:0] adr;
      logic [4:0]  dep;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cram_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .clkForce1777 (clkForce1777),
      .stall        (stall),
      .j            (j),
      .call         (call),
      .ret          (ret),
      .dispEn       (dispEn),
      .dispIn       (dispIn),
      .dramEn       (dramEn),
      .DRAMj        (DRAMj),
      .skipEn       (skipEn),
      .skipTrue     (skipTrue),
      .cradr        (cradr),
      .stackDepth   (stackDepth),
      .stackErr     (stackErr)
   );

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
      end
   endtask

   task automatic clr();
      reset        = 1'b0;
      clkForce1777 = 1'b0;
      stall        = 1'b0;
      j            = '0;
      call         = 1'b0;
      ret          = 1'b0;
      dispEn       = 1'b0;
      dispIn       = '0;
      dramEn       = 1'b0;
      DRAMj        = '0;
      skipEn       = 1'b0;
      skipTrue     = 1'b0;
   endtask

   // Queue the expectation for the inputs now driven, clock once, then compare.
   task automatic step(input string tag, input logic [10:0] e_adr,
                       input logic [4:0] e_dep, input logic e_err);
      exp_t e;
      exp_q.push_back('{tag, e_adr, e_dep, e_err});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({e.tag, "_cradr"}, cradr, e.adr);
      check({e.tag, "_depth"}, 11'(stackDepth), 11'(e.dep));
      check({e.tag, "_err"}, 11'(stackErr), 11'(e.err));
   endtask

   initial begin
      clr();
      reset = 1'b1; j = 11'o0100;
      step("rst", 11'o0000, 5'd0, 1'b0);
      clkForce1777 = 1'b1; call = 1'b1;
      step("rst_force_call", 11'o0000, 5'd0, 1'b0);

      clr(); j = 11'o0100;
      step("jump_0100", 11'o0100, 5'd0, 1'b0);

      j = 11'o0200;
      step("jump_0200", 11'o0200, 5'd0, 1'b0);
      call = 1'b1; j = 11'o0500;
      step("call_0500", 11'o0500, 5'd1, 1'b0);
      call = 1'b0; ret = 1'b1; j = 11'o0001;
      step("ret_0201", 11'o0201, 5'd0, 1'b0);

      ret = 1'b0; j = 11'o0300;
      step("jump_0300", 11'o0300, 5'd0, 1'b0);
      clkForce1777 = 1'b1; stall = 1'b1; j = 11'o0000; ret = 1'b1;
      step("force_stall", 11'o1777, 5'd1, 1'b0);
      clr(); ret = 1'b1;
      step("ret_after_force", 11'o0300, 5'd0, 1'b0);

      clr(); j = 11'o0400; dispEn = 1'b1; dispIn = 4'hA;
      step("disp", 11'o0412, 5'd0, 1'b0);
      clr(); j = 11'o0400; skipEn = 1'b1; skipTrue = 1'b1;
      step("skip_true", 11'o0401, 5'd0, 1'b0);
      skipTrue = 1'b0;
      step("skip_false", 11'o0400, 5'd0, 1'b0);
      clr(); dramEn = 1'b1; j = 11'o2000; DRAMj = 10'o0123;
      step("dram", 11'o2123, 5'd0, 1'b0);
      dispEn = 1'b1; dispIn = 4'hF; skipEn = 1'b1; skipTrue = 1'b1;
      j = 11'o0000; DRAMj = 10'o0777;
      step("dram_over_disp", 11'o0777, 5'd0, 1'b0);
      dramEn = 1'b0; j = 11'o0400; dispIn = 4'h3;
      step("disp_over_skip", 11'o0403, 5'd0, 1'b0);

      clr(); call = 1'b1; j = 11'o0010;
      step("call1", 11'o0010, 5'd1, 1'b0);
      j = 11'o0020;
      step("call2", 11'o0020, 5'd2, 1'b0);
      j = 11'o0600;
      step("call3", 11'o0600, 5'd3, 1'b0);
      ret = 1'b1; j = 11'o0000;
      step("call_ret", 11'o0020, 5'd3, 1'b0);
      ret = 1'b0; stall = 1'b1; j = 11'o0777;
      step("stall1", 11'o0020, 5'd3, 1'b0);
      step("stall2", 11'o0020, 5'd3, 1'b0);
      clr(); ret = 1'b1;
      step("pop_replaced", 11'o0600, 5'd2, 1'b0);
      step("pop2", 11'o0010, 5'd1, 1'b0);
      step("pop3", 11'o0403, 5'd0, 1'b0);

      clr(); reset = 1'b1;
      step("rst2", 11'o0000, 5'd0, 1'b0);
      clr(); ret = 1'b1; j = 11'o0007;
      step("underflow", 11'o0007, 5'd0, 1'b1);
      clr(); j = 11'o0001;
      step("err_sticky", 11'o0001, 5'd0, 1'b1);
      call = 1'b1; ret = 1'b1; j = 11'o0040;
      step("call_ret_empty", 11'o0040, 5'd1, 1'b1);
      clr(); ret = 1'b1;
      step("pop_after_empty_cr", 11'o0001, 5'd0, 1'b1);

      clr(); reset = 1'b1;
      step("rst3", 11'o0000, 5'd0, 1'b0);
      clr(); call = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         j = 11'(i);
         step($sformatf("ovf_call%0d", i), 11'(i), (i > 16) ? 5'd16 : 5'(i), i > 16);
      end
      clr(); ret = 1'b1;
      step("pop_after_ovf", 11'o0017, 5'd15, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cram_sequencer.md
CRAM_SEQUENCER -- requirements
Module: cram_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 Parameter STACK_DEPTH, default 16, SHALL set the number of call-stack entries.
REQ-003 Parameter ADR_W, default 11, SHALL set the CRAM address width.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- clkForce1777  in  1  trap request; force next address to 1777 octal.
- stall  in  1  hold the sequencer (memory or clock wait).
- j  in  ADR_W  J field of the current microword.
- call  in  1  push return address.
- ret  in  1  pop stack (return dispatch).
- dispEn  in  1  local dispatch.
- dispIn  in  4  dispatch data, ORed into j[3:0].
- dramEn  in  1  DRAM J dispatch.
- DRAMj  in  10  DRAM J value.
- skipEn  in  1  skip field active.
- skipTrue  in  1  selected condition is true.
- cradr  out  ADR_W  registered current CRAM address.
- stackDepth  out  5  number of valid stack entries.
- stackErr  out  1  sticky overflow/underflow flag.

Function
REQ-005 cradr SHALL update only on the clk edge; all next-address selection is combinational from the current inputs and cradr.
REQ-006 Precedence, highest first: reset, clkForce1777, stall, ret, dramEn, dispEn, skipEn, plain J.
REQ-007 clkForce1777: next cradr SHALL be 11'o1777, and the current cradr SHALL be pushed. Force overrides stall, and all other controls are ignored that cycle.
REQ-008 stall without force: cradr, the stack and stackDepth SHALL hold, and call/ret SHALL be ignored.
REQ-009 ret: next cradr SHALL be (stack top OR j), and stackDepth SHALL decrement.
REQ-010 dramEn: next cradr SHALL be {j[10], DRAMj}.
REQ-011 dispEn: next cradr SHALL be j OR {7'b0, dispIn}.
REQ-012 skipEn: next cradr SHALL be j with bit 0 ORed with skipTrue.
REQ-013 With none of the above asserted, next cradr SHALL be j.
REQ-014 call without ret: the current cradr SHALL be pushed, and the next address is chosen per REQ-010 to REQ-013.
REQ-015 call and ret in the same cycle: the top entry SHALL be replaced by the current cradr, stackDepth SHALL be unchanged, and next cradr SHALL be (old top OR j).
REQ-016 Push when stackDepth == STACK_DEPTH: the write SHALL be discarded, the depth held, and stackErr set.
REQ-017 Pop when stackDepth == 0: the top SHALL read as 0 (next cradr = j), the depth stays 0, and stackErr is set.
REQ-018 call+ret with depth 0: treated as underflow per REQ-017; the push still occurs and the depth becomes 1.
REQ-019 stackErr SHALL remain set until reset.
REQ-020 Address arithmetic SHALL be OR-only; no carries and no wrap.

Reset
REQ-021 On reset, cradr SHALL be 0, stackDepth 0, and stackErr 0. Stack contents need not be cleared.
REQ-022 Reset SHALL take precedence over clkForce1777 and stall. An in-flight call or return asserted together with reset SHALL be discarded.

Structure
REQ-023 A shared package cram_pkg SHALL hold ADR_W, FORCE_ADR (11'o1777), STACK_DEPTH_DEF, and the next-address-source enumeration (FORCE, HOLD, RET, DRAM, DISP, SKIP, JUMP).
REQ-024 The stack SHALL be a single sub-module, cram_stack, with push/pop/replace controls, and top, depth, ovf and unf outputs.
REQ-025 The top level SHALL contain the source-select logic and the cradr register only.

Verification
REQ-026 Reset, then j=11'o0100 for one cycle -> cradr=0 during reset, then 11'o0100 the next cycle.
REQ-027 cradr=11'o0200, call with j=11'o0500 -> cradr=11'o0500, depth 1. Then ret with j=11'o0001 -> cradr=11'o0201, depth 0.
REQ-028 cradr=11'o0300, clkForce1777 with stall=1 -> cradr=11'o1777, depth 1, top=11'o0300.
REQ-029 j=11'o0400 with dispEn and dispIn=4'hA -> cradr=11'o0412. j=11'o0400 with skipEn and skipTrue=1 -> 11'o0401. dramEn with j[10]=1 and DRAMj=10'o0123 -> 11'o2123.
REQ-030 Overflow and underflow:
- 17 consecutive calls -> depth 16 and stackErr=1 after the 17th.
- After reset, a single ret with j=11'o0007 -> cradr=11'o0007, stackErr=1.
REQ-031 Depth 3, call+ret together with cradr=11'o0600 and j=0 -> cradr = old top, depth 3, new top=11'o0600. Then stall=1 for 2 cycles with call asserted -> no change.
